// File: rtl/nios_mul_pkg.sv
// rtl/nios_mul_pkg.sv - shared types and constants for the Nios MULX sequencer
package nios_mul_pkg;

   localparam int MUL_DATA_W = 32;
   localparam int MUL_PART_W = 16;

   typedef enum logic [1:0] {
      MUL_LO  = 2'b00,
      MULX_SS = 2'b01,
      MULX_SU = 2'b10,
      MULX_UU = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      ISSUE = 2'b01,
      DRAIN = 2'b10,
      FIX   = 2'b11
   } state_e;

   // Encoding doubles as the issue index k, so the sequencer counter maps straight onto it.
   typedef enum logic [1:0] {
      LL = 2'b00,
      LH = 2'b01,
      HL = 2'b10,
      HH = 2'b11
   } pp_sel_e;

   function automatic logic [5:0] pp_shift(input pp_sel_e sel);
      logic [5:0] sh;
      case (sel)
         LL:      sh = 6'd0;
         LH, HL:  sh = 6'd16;
         default: sh = 6'd32;
      endcase
      return sh;
   endfunction

endpackage

// File: rtl/nios_mul16_reg.sv
// rtl/nios_mul16_reg.sv - unsigned 16x16->32 multiplier with PP_PIPE output registers
module nios_mul16_reg #(
   parameter int PART_W  = 16,
   parameter int PP_PIPE = 1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [PART_W-1:0]     a,
   input  logic [PART_W-1:0]     b,
   output logic [2*PART_W-1:0]   p
);

   logic [2*PART_W-1:0] r_p [PP_PIPE];
   logic [2*PART_W-1:0] w_prod;

   assign w_prod = {{PART_W{1'b0}}, a} * {{PART_W{1'b0}}, b};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < PP_PIPE; i++) begin
            r_p[i] <= '0;
         end
      end else begin
         r_p[0] <= w_prod;
         for (int i = 1; i < PP_PIPE; i++) begin
            r_p[i] <= r_p[i-1];
         end
      end
   end

   assign p = r_p[PP_PIPE-1];

endmodule

// File: rtl/nios_mulx_sequencer.sv
// rtl/nios_mulx_sequencer.sv - multi-cycle 32x32 MUL/MULX sequencer over a 16x16 multiplier
// Optional NIOS_MULX_ZERO_SKIP_EN: zero operand completes in two cycles without issuing.
module nios_mulx_sequencer
   import nios_mul_pkg::*;
#(
   parameter int DATA_W  = MUL_DATA_W,
   parameter int PART_W  = MUL_PART_W,
   parameter int PP_PIPE = 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [1:0]        op,
   input  logic [DATA_W-1:0] src1,
   input  logic [DATA_W-1:0] src2,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] result
);

   localparam int ACC_W = 2 * DATA_W;

   if (DATA_W != 32 || PART_W != DATA_W / 2) begin : g_bad_width
      $error("nios_mulx_sequencer: DATA_W must be 32 and PART_W DATA_W/2");
   end
   if (PP_PIPE < 1 || PP_PIPE > 2) begin : g_bad_pipe
      $error("nios_mulx_sequencer: PP_PIPE must be 1 or 2");
   end

   state_e              r_state;
   op_e                 r_op;
   logic [DATA_W-1:0]   r_a;
   logic [DATA_W-1:0]   r_b;
   logic [1:0]          r_k;
   logic [1:0]          r_drain;
   logic                r_busy;
   logic                r_done;
   logic [DATA_W-1:0]   r_result;
   logic [ACC_W-1:0]    r_acc;
   logic                r_vld [PP_PIPE];
   logic [1:0]          r_sel [PP_PIPE];

   logic                w_accept;
   logic                w_zero;
   logic [1:0]          w_last_k;
   pp_sel_e             w_sel;
   pp_sel_e             w_out_sel;
   logic [PART_W-1:0]   w_ma;
   logic [PART_W-1:0]   w_mb;
   logic [DATA_W-1:0]   w_prod;
   logic [ACC_W-1:0]    w_addend;
   logic [DATA_W-1:0]   w_corr_a;
   logic [DATA_W-1:0]   w_corr_b;
   logic [DATA_W-1:0]   w_hi;

   assign w_accept = start && (r_state == IDLE);

`ifdef NIOS_MULX_ZERO_SKIP_EN
   assign w_zero = (src1 == '0) || (src2 == '0);
`else
   assign w_zero = 1'b0;
`endif

   assign w_last_k = (r_op == MUL_LO) ? 2'd2 : 2'd3;

   assign w_sel = pp_sel_e'(r_k);
   assign w_ma  = (w_sel == HL || w_sel == HH) ? r_a[DATA_W-1:PART_W] : r_a[PART_W-1:0];
   assign w_mb  = (w_sel == LH || w_sel == HH) ? r_b[DATA_W-1:PART_W] : r_b[PART_W-1:0];

   nios_mul16_reg #(
      .PART_W  (PART_W),
      .PP_PIPE (PP_PIPE)
   ) u_mul (
      .clk     (clk),
      .reset_n (reset_n),
      .a       (w_ma),
      .b       (w_mb),
      .p       (w_prod)
   );

   assign w_out_sel = pp_sel_e'(r_sel[PP_PIPE-1]);
   assign w_addend  = {{DATA_W{1'b0}}, w_prod} << pp_shift(w_out_sel);

   // Signed operands are handled by unsigned multiply plus high-word subtraction of the other operand.
   assign w_corr_a = ((r_op == MULX_SS || r_op == MULX_SU) && r_a[DATA_W-1]) ? r_b : '0;
   assign w_corr_b = ((r_op == MULX_SS) && r_b[DATA_W-1]) ? r_a : '0;
   assign w_hi     = r_acc[ACC_W-1:DATA_W] - w_corr_a - w_corr_b;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_acc <= '0;
         for (int i = 0; i < PP_PIPE; i++) begin
            r_vld[i] <= 1'b0;
            r_sel[i] <= 2'd0;
         end
      end else begin
         r_vld[0] <= (r_state == ISSUE);
         r_sel[0] <= r_k;
         for (int i = 1; i < PP_PIPE; i++) begin
            r_vld[i] <= r_vld[i-1];
            r_sel[i] <= r_sel[i-1];
         end
         if (w_accept) begin
            r_acc <= '0;
         end else if (r_vld[PP_PIPE-1]) begin
            r_acc <= r_acc + w_addend;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= IDLE;
         r_op     <= MUL_LO;
         r_a      <= '0;
         r_b      <= '0;
         r_k      <= 2'd0;
         r_drain  <= 2'd0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_result <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_op    <= op_e'(op);
                  r_a     <= src1;
                  r_b     <= src2;
                  r_k     <= 2'd0;
                  r_drain <= 2'd0;
                  r_busy  <= 1'b1;
                  r_state <= w_zero ? FIX : ISSUE;
               end
            end
            ISSUE: begin
               r_k <= r_k + 2'd1;
               if (r_k == w_last_k) begin
                  r_state <= DRAIN;
               end
            end
            DRAIN: begin
               if (r_drain == 2'(PP_PIPE - 1)) begin
                  r_drain <= 2'd0;
                  r_state <= FIX;
               end else begin
                  r_drain <= r_drain + 2'd1;
               end
            end
            FIX: begin
               r_result <= (r_op == MUL_LO) ? r_acc[DATA_W-1:0] : w_hi;
               r_done   <= 1'b1;
               r_busy   <= 1'b0;
               r_state  <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign busy   = r_busy;
   assign done   = r_done;
   assign result = r_result;

endmodule

// File: tb/tb_nios_mulx_sequencer.sv
// tb/tb_nios_mulx_sequencer.sv - directed scoreboard bench for nios_mulx_sequencer
module tb_nios_mulx_sequencer;

   logic        clk;
   logic        reset_n;
   logic        start;
   logic [1:0]  op;
   logic [31:0] src1;
   logic [31:0] src2;
   logic        busy;
   logic        done;
   logic [31:0] result;

   int pass_cnt  = 0;
   int total_cnt = 0;
   int cyc       = 0;

`ifdef NIOS_MULX_ZERO_SKIP_EN
   localparam int ZLAT = 2;
`else
   localparam int ZLAT = 7;
`endif

   typedef struct {
      logic [31:0] res;
      int          cyc;
   } exp_t;

   exp_t sb[$];

   nios_mulx_sequencer dut (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (start),
      .op      (op),
      .src1    (src1),
      .src2    (src2),
      .busy    (busy),
      .done    (done),
      .result  (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
   endtask

   always @(negedge clk) begin
      if (reset_n && done) begin
         if (sb.size() == 0) begin
            chk("spurious_done", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("result", result, e.res);
            chk("done_cycle", 32'(cyc), 32'(e.cyc));
         end
      end
   end

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Drives start for one cycle; scored requests push their expected result and done cycle.
   task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic scored, input logic [31:0] exp_res, input int lat);
      exp_t e;
      start = 1'b1;
      op    = o;
      src1  = a;
      src2  = b;
      if (scored) begin
         e.res = exp_res;
         e.cyc = cyc + lat;
         sb.push_back(e);
      end
      step(1);
      start = 1'b0;
      op    = 2'b00;
      src1  = 32'hA5A5_5A5A;
      src2  = 32'h5A5A_A5A5;
   endtask

   task automatic wait_done();
      int n = 0;
      while (!done && n < 40) begin
         step(1);
         n++;
      end
      chk("wait_done_timeout", 32'(done), 32'd1);
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((busy || sb.size() != 0) && n < 60) begin
         step(1);
         n++;
      end
      chk("idle_timeout", 32'(sb.size()), 32'd0);
   endtask

   initial begin
      reset_n = 1'b0;
      start   = 1'b0;
      op      = 2'b00;
      src1    = '0;
      src2    = '0;
      step(3);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_done", 32'(done), 32'd0);
      chk("reset_result", result, 32'd0);
      reset_n = 1'b1;
      step(2);

      issue(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE, 7);
      for (int i = 1; i <= 6; i++) begin
         chk("uu_busy_high", 32'(busy), 32'd1);
         chk("uu_done_low", 32'(done), 32'd0);
         step(1);
      end
      chk("uu_busy_low_at_done", 32'(busy), 32'd0);
      chk("uu_done_pulse", 32'(done), 32'd1);
      step(1);
      chk("uu_done_one_cycle", 32'(done), 32'd0);

      issue(2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 32'hFFFF_FFFF, 7);
      wait_idle();
      issue(2'b10, 32'h8000_0000, 32'h0000_0002, 1'b1, 32'hFFFF_FFFF, 7);
      wait_idle();
      issue(2'b01, 32'h8000_0000, 32'h8000_0000, 1'b1, 32'h4000_0000, 7);
      wait_idle();
      issue(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 7);
      wait_idle();
      issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h0000_0001, 6);
      wait_idle();

      issue(2'b00, 32'h1234_5678, 32'h0000_0010, 1'b1, 32'h2345_6780, 6);
      wait_done();
      issue(2'b11, 32'h0001_0000, 32'h0001_0000, 1'b1, 32'h0000_0001, 7);
      wait_idle();

      issue(2'b11, 32'h0002_0000, 32'h0003_0000, 1'b1, 32'h0000_0006, 7);
      issue(2'b00, 32'hFFFF_FFFF, 32'h1234_5678, 1'b0, 32'h0, 0);
      wait_idle();
      chk("ignored_start_result_held", result, 32'h0000_0006);

      issue(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0, 0);
      step(2);
      #2;
      reset_n = 1'b0;
      #1;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_result", result, 32'd0);
      step(2);
      reset_n = 1'b1;
      step(10);
      chk("abort_no_done", 32'(sb.size()), 32'd0);
      issue(2'b11, 32'h0000_0003, 32'h0000_0005, 1'b1, 32'h0000_0000, 7);
      wait_idle();

      issue(2'b01, 32'h0000_0000, 32'hDEAD_BEEF, 1'b1, 32'h0000_0000, ZLAT);
      wait_idle();

      step(3);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
